nes_mem_arbiter: RTL
====================

NES_MEM_ARBITER -- requirements
Module: nes_mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16: maximum cycles to wait for mem_ack before the access is aborted (legal range 2..255).
REQ-002 SHALL have port clk  in  1  system clock; all state changes on the rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port prg_req  in  1  single-cycle CPU access request, already qualified by the mapper's prg_allow.
REQ-005 SHALL have ports prg_we (in, 1), prg_addr (in, 22), prg_wdata (in, 8): CPU write enable, mapped address and write data.
REQ-006 SHALL have ports prg_rdata (out, 8) and prg_done (out, 1): CPU read data and one-cycle completion pulse.
REQ-007 SHALL have ports chr_req, chr_we, chr_addr[21:0], chr_wdata[7:0], chr_rdata[7:0], chr_done: the PPU equivalents of REQ-004..006.
REQ-008 SHALL have ports mem_req (out, 1), mem_we (out, 1), mem_addr (out, 22), mem_wdata (out, 8): external memory request, held until ack or timeout.
REQ-009 SHALL have ports mem_rdata (in, 8) and mem_ack (in, 1): read data, valid in the same cycle as mem_ack.
REQ-010 SHALL have port timeout_err  out  1  sticky flag, set on any timeout.

Function
REQ-011 SHALL capture {we, addr, wdata} into a per-client pending slot on the edge where req=1 and that slot is empty.
REQ-012 SHALL ignore req while the client's slot is pending or in service; slot contents stay unchanged.
REQ-013 SHALL run the FSM IDLE -> ISSUE -> DONE -> IDLE.
REQ-014 SHALL, in IDLE with one slot pending, grant it and register mem_req=1 with that slot's we, addr and wdata at the next edge.
REQ-015 SHALL, when both slots are pending in IDLE, grant round-robin: the client not granted last wins; last_grant resets to PRG, so CHR wins the first tie.
REQ-016 SHALL capture a client request at edge E and drive mem_req high from edge E+1 when the FSM is in IDLE; 1-cycle latency.
REQ-017 SHALL hold mem_req, mem_we, mem_addr and mem_wdata stable in ISSUE until mem_ack is sampled high.
REQ-018 SHALL, on mem_ack sampled high at edge A: drop mem_req, latch mem_rdata into the granted client's rdata, clear its slot and enter DONE at A.
REQ-019 SHALL assert the granted client's done for exactly the one cycle in DONE; the earliest next mem_req is edge A+2.
REQ-020 SHALL hold each rdata until that client's next completion; writes leave rdata unchanged.
REQ-021 SHALL count ISSUE cycles with an 8-bit counter; when it reaches TIMEOUT_CYCLES without ack: drop mem_req, load rdata=8'hFF on reads, set timeout_err, enter DONE.
REQ-022 SHALL treat mem_ack in IDLE or DONE as spurious: ignored, no state change.
REQ-023 SHALL accept a new req from the non-granted client in any state, including the completion cycle.
REQ-024 SHALL accept a new req from the granted client from its done cycle onward.
REQ-025 SHALL never assert prg_done and chr_done in the same cycle.

Reset
REQ-026 SHALL, while rst_n=0: all outputs 0 (except rdata 8'h00), FSM=IDLE, slots empty, counter 0, last_grant=PRG, timeout_err=0.
REQ-027 SHALL abort any in-flight access on reset mid-ISSUE with no done pulse; mem_ack after rst_n rises is treated per REQ-022.

Structure
REQ-028 SHALL take state_t {IDLE, ISSUE, DONE}, client_t {PRG, CHR} and ADDR_W=22 from shared package nes_mem_pkg.
REQ-029 SHALL implement the pending slot (REQ-011/012) as sub-module nes_mem_slot, instantiated once per client.

Verification
REQ-030 SHALL cover single PRG read: prg_req, addr 22'h00_8000 at edge 0 -> mem_req from edge 1; ack with 8'h4C at edge 3 -> prg_done=1 in cycle 3..4, prg_rdata=8'h4C.
REQ-031 SHALL cover simultaneous prg_req and chr_req after reset -> CHR serviced first, then PRG; next tie -> CHR again (last grant was PRG).
REQ-032 SHALL cover CHR write: chr_we=1, addr 22'h20_0123, data 8'hA5 -> mem_we=1, mem_wdata=8'hA5; chr_rdata unchanged after chr_done.
REQ-033 SHALL cover timeout: no ack for 16 ISSUE cycles -> mem_req drops, rdata=8'hFF, done pulses, timeout_err=1 until reset.
REQ-034 SHALL cover rst_n low in ISSUE, then ack -> no done pulse, slots empty, mem_req=0.
REQ-035 SHALL cover second prg_req while PRG pending -> ignored; only the first address appears on mem_addr.

Source files
------------

// File: rtl/nes_mem_pkg.sv
// rtl/nes_mem_pkg.sv - shared types and constants for the NES memory arbiter
package nes_mem_pkg;

  localparam int ADDR_W = 22;
  localparam int DATA_W = 8;

  typedef logic [1:0] state_t;
  localparam state_t IDLE  = 2'd0;
  localparam state_t ISSUE = 2'd1;
  localparam state_t DONE  = 2'd2;

  typedef enum logic {
    PRG = 1'b0,
    CHR = 1'b1
  } client_t;

  // Round-robin choice: on a tie the client that did not win last time goes next.
  function automatic client_t rr_pick(input logic prg_pend, input logic chr_pend,
                                      input client_t last_grant);
    if (prg_pend && chr_pend) begin
      return (last_grant == PRG) ? CHR : PRG;
    end else if (chr_pend) begin
      return CHR;
    end else begin
      return PRG;
    end
  endfunction

endpackage

// File: rtl/nes_mem_arbiter_if.sv
// rtl/nes_mem_arbiter_if.sv - external memory request/ack bus
interface nes_mem_arbiter_if;

  logic                             mem_req;
  logic                             mem_we;
  logic [nes_mem_pkg::ADDR_W-1:0]   mem_addr;
  logic [nes_mem_pkg::DATA_W-1:0]   mem_wdata;
  logic [nes_mem_pkg::DATA_W-1:0]   mem_rdata;
  logic                             mem_ack;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata,
    output mem_ack
  );

endinterface

// File: rtl/nes_mem_slot.sv
// rtl/nes_mem_slot.sv - single-entry pending request slot for one arbiter client
module nes_mem_slot
  import nes_mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              clear,
  output logic              pending,
  output logic              pend_we,
  output logic [ADDR_W-1:0] pend_addr,
  output logic [DATA_W-1:0] pend_wdata
);

  // The slot stays occupied while in service, so requests are dropped until clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending    <= 1'b0;
      pend_we    <= 1'b0;
      pend_addr  <= '0;
      pend_wdata <= '0;
    end else if (clear) begin
      pending <= 1'b0;
    end else if (req && !pending) begin
      pending    <= 1'b1;
      pend_we    <= we;
      pend_addr  <= addr;
      pend_wdata <= wdata;
    end
  end

endmodule

// File: rtl/nes_mem_arbiter.sv
// rtl/nes_mem_arbiter.sv - round-robin PRG/CHR arbiter onto one external memory port
module nes_mem_arbiter
  import nes_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              prg_req,
  input  logic              prg_we,
  input  logic [ADDR_W-1:0] prg_addr,
  input  logic [DATA_W-1:0] prg_wdata,
  output logic [DATA_W-1:0] prg_rdata,
  output logic              prg_done,

  input  logic              chr_req,
  input  logic              chr_we,
  input  logic [ADDR_W-1:0] chr_addr,
  input  logic [DATA_W-1:0] chr_wdata,
  output logic [DATA_W-1:0] chr_rdata,
  output logic              chr_done,

  nes_mem_arbiter_if.master mem,

  output logic              timeout_err
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t            state_q;
  client_t           grant_q;
  client_t           last_grant_q;
  client_t           pick;
  logic [7:0]        cnt_q;
  logic [DATA_W-1:0] prg_rdata_q;
  logic [DATA_W-1:0] chr_rdata_q;
  logic              timeout_err_q;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;

  logic              prg_pend;
  logic              prg_s_we;
  logic [ADDR_W-1:0] prg_s_addr;
  logic [DATA_W-1:0] prg_s_wdata;
  logic              chr_pend;
  logic              chr_s_we;
  logic [ADDR_W-1:0] chr_s_addr;
  logic [DATA_W-1:0] chr_s_wdata;

  logic              timeout_hit;
  logic              finish;
  logic              prg_clear;
  logic              chr_clear;

  assign timeout_hit = (cnt_q == TO_LAST);
  assign finish      = (state_q == ISSUE) && (mem.mem_ack || timeout_hit);
  assign prg_clear   = finish && (grant_q == PRG);
  assign chr_clear   = finish && (grant_q == CHR);
  assign pick        = rr_pick(prg_pend, chr_pend, last_grant_q);

  nes_mem_slot u_prg_slot (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (prg_req),
    .we         (prg_we),
    .addr       (prg_addr),
    .wdata      (prg_wdata),
    .clear      (prg_clear),
    .pending    (prg_pend),
    .pend_we    (prg_s_we),
    .pend_addr  (prg_s_addr),
    .pend_wdata (prg_s_wdata)
  );

  nes_mem_slot u_chr_slot (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (chr_req),
    .we         (chr_we),
    .addr       (chr_addr),
    .wdata      (chr_wdata),
    .clear      (chr_clear),
    .pending    (chr_pend),
    .pend_we    (chr_s_we),
    .pend_addr  (chr_s_addr),
    .pend_wdata (chr_s_wdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      grant_q       <= PRG;
      last_grant_q  <= PRG;
      cnt_q         <= 8'd0;
      prg_rdata_q   <= '0;
      chr_rdata_q   <= '0;
      timeout_err_q <= 1'b0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (prg_pend || chr_pend) begin
            state_q      <= ISSUE;
            grant_q      <= pick;
            last_grant_q <= pick;
            cnt_q        <= 8'd0;
            mem_req_q    <= 1'b1;
            mem_we_q     <= (pick == CHR) ? chr_s_we    : prg_s_we;
            mem_addr_q   <= (pick == CHR) ? chr_s_addr  : prg_s_addr;
            mem_wdata_q  <= (pick == CHR) ? chr_s_wdata : prg_s_wdata;
          end
        end
        ISSUE: begin
          // Ack wins over a timeout landing on the same edge.
          if (mem.mem_ack) begin
            state_q   <= DONE;
            mem_req_q <= 1'b0;
            if (!mem_we_q) begin
              if (grant_q == CHR) chr_rdata_q <= mem.mem_rdata;
              else                prg_rdata_q <= mem.mem_rdata;
            end
          end else if (timeout_hit) begin
            state_q       <= DONE;
            mem_req_q     <= 1'b0;
            timeout_err_q <= 1'b1;
            if (!mem_we_q) begin
              if (grant_q == CHR) chr_rdata_q <= 8'hFF;
              else                prg_rdata_q <= 8'hFF;
            end
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q   <= IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign mem.mem_req   = mem_req_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;

  assign prg_rdata   = prg_rdata_q;
  assign chr_rdata   = chr_rdata_q;
  assign prg_done    = (state_q == DONE) && (grant_q == PRG);
  assign chr_done    = (state_q == DONE) && (grant_q == CHR);
  assign timeout_err = timeout_err_q;

endmodule
